// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: FSM state encoding (common with the receiver),
// default line configuration and the baud divisor helper.
package uart_transmitter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_DATA  = 2'b10,
        ST_STOP  = 2'b11
    } uart_state_e;

    localparam int UART_CLK_FREQ = 50_000_000;
    localparam int UART_BAUD     = 115_200;

    // Clocks per bit; integer division, remainder is dropped.
    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses tick for one cycle every DIV clocks. restart
// re-aligns the period so bit edges follow an external event (frame accept
// on transmit, start-bit edge on receive).
module uart_baud_tick #(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CNT_LAST);

    // Free count 0..DIV-1, cleared on reset or restart, wrapping on tick.
    always_ff @(posedge clk) begin
        if (rst || restart) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit path: start bit, DATA_BITS data bits (MSB or LSB first),
// STOP_BITS stop bits. tx, txBusy and txDone are all registered.
//
// state | meaning
// IDLE  | line high, waiting for tx_start
// START | start bit (0) for one bit period
// DATA  | shifting data bits out, bit_cnt_q counts bits sent
// STOP  | stop bit(s) (1), bit_cnt_q counts stop periods
module uart_transmitter
    import uart_transmitter_pkg::*;
#(
    parameter int CLK_FREQ  = UART_CLK_FREQ,
    parameter int BAUD      = UART_BAUD,
    parameter int DATA_BITS = 8,
    parameter int STOP_BITS = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 txEn,
    input  logic                 tx_start,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 tx,
    output logic                 txBusy,
    output logic                 txDone
);

    localparam int DIV = calc_div(CLK_FREQ, BAUD);
    localparam int BCW = 3;
    localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

    if (DIV < 2) begin : g_bad_div
        $error("uart_transmitter: CLK_FREQ/BAUD must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
        $error("uart_transmitter: DATA_BITS must be 5..8");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_transmitter: STOP_BITS must be 1..2");
    end

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
    logic                 tx_q, tx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic                 tick;
    logic                 restart;
    logic                 out_bit;
    logic [DATA_BITS-1:0] shifted;

    // Holding the timer in restart while idle means it reads 0 right after
    // the accept edge, so bit edges line up with the accept cycle.
    assign restart = (state_q == ST_IDLE) || !txEn;

    uart_baud_tick #(
        .DIV(DIV)
    ) u_baud_tick (
        .clk    (clk),
        .rst    (rst),
        .restart(restart),
        .tick   (tick)
    );

    assign out_bit = (MSB_FIRST != 0) ? shreg_q[DATA_BITS-1] : shreg_q[0];
    assign shifted = (MSB_FIRST != 0) ? (shreg_q << 1) : (shreg_q >> 1);

    assign tx     = tx_q;
    assign txBusy = busy_q;
    assign txDone = done_q;

    // State and datapath registers; reset leaves the line idle-high.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next state: advance only on baud ticks; disable forces IDLE.
    always_comb begin
        state_d = state_q;
        if (!txEn) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:  if (tx_start) state_d = ST_START;
                ST_START: if (tick) state_d = ST_DATA;
                ST_DATA:  if (tick && bit_cnt_q == LAST_DATA) state_d = ST_STOP;
                ST_STOP:  if (tick && bit_cnt_q == LAST_STOP) state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs, shift register and bit counter for the upcoming cycle.
    always_comb begin
        tx_d      = tx_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        shreg_d   = shreg_q;
        bit_cnt_d = bit_cnt_q;
        if (!txEn) begin
            tx_d      = 1'b1;
            busy_d    = 1'b0;
            bit_cnt_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    tx_d      = 1'b1;
                    busy_d    = 1'b0;
                    bit_cnt_d = '0;
                    if (tx_start) begin
                        shreg_d = in_data;
                        tx_d    = 1'b0;
                        busy_d  = 1'b1;
                    end
                end
                ST_START: begin
                    if (tick) begin
                        tx_d      = out_bit;
                        shreg_d   = shifted;
                        bit_cnt_d = '0;
                    end
                end
                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt_q == LAST_DATA) begin
                            tx_d      = 1'b1;
                            bit_cnt_d = '0;
                        end else begin
                            tx_d      = out_bit;
                            shreg_d   = shifted;
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (tick) begin
                        if (bit_cnt_q == LAST_STOP) begin
                            tx_d      = 1'b1;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
                            bit_cnt_d = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    tx_d   = 1'b1;
                    busy_d = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: instance 0 uses 8N1 MSB-first, instance 1
// uses 5 data bits, 2 stop bits, LSB-first, both at 16 clocks per bit.
// A frame-position model predicts tx/txBusy/txDone every cycle; directed
// sequences add literal expectations on bit levels, timing and decoded data.
module tb_uart_transmitter;

    localparam int DIV = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] en  = 2'b11;
    logic [1:0] st  = 2'b00;
    logic [7:0] din0 = '0;
    logic [4:0] din1 = '0;
    logic [1:0] txs, busys, dones;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_transmitter #(
        .CLK_FREQ(1600), .BAUD(100), .DATA_BITS(8), .STOP_BITS(1), .MSB_FIRST(1)
    ) u_dut0 (
        .clk(clk), .rst(rst), .txEn(en[0]), .tx_start(st[0]), .in_data(din0),
        .tx(txs[0]), .txBusy(busys[0]), .txDone(dones[0])
    );

    uart_transmitter #(
        .CLK_FREQ(1600), .BAUD(100), .DATA_BITS(5), .STOP_BITS(2), .MSB_FIRST(0)
    ) u_dut1 (
        .clk(clk), .rst(rst), .txEn(en[1]), .tx_start(st[1]), .in_data(din1),
        .tx(txs[1]), .txBusy(busys[1]), .txDone(dones[1])
    );

    // ---------------- behavioural model ----------------
    int         p_db[2]  = '{8, 5};
    int         p_sb[2]  = '{1, 2};
    int         p_msb[2] = '{1, 0};
    logic       m_act[2] = '{1'b0, 1'b0};
    int         m_pos[2] = '{0, 0};
    logic [7:0] m_data[2];
    logic       e_tx[2]   = '{1'b1, 1'b1};
    logic       e_busy[2] = '{1'b0, 1'b0};
    logic       e_done[2] = '{1'b0, 1'b0};

    // Level of bit-slot k of a frame: start, data, then stop.
    function automatic logic fbit(input int k, input logic [7:0] d, input int db, input int msb);
        if (k == 0) return 1'b0;
        if (k <= db) return (msb != 0) ? d[db - k] : d[k - 1];
        return 1'b1;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            for (int n = 0; n < 2; n++) begin
                int f;
                f = (1 + p_db[n] + p_sb[n]) * DIV;
                if (rst || !en[n]) begin
                    m_act[n] = 1'b0; e_tx[n] = 1'b1; e_busy[n] = 1'b0; e_done[n] = 1'b0;
                end else if (m_act[n]) begin
                    m_pos[n] = m_pos[n] + 1;
                    e_done[n] = 1'b0;
                    if (m_pos[n] == f) begin
                        m_act[n] = 1'b0; e_tx[n] = 1'b1; e_busy[n] = 1'b0; e_done[n] = 1'b1;
                    end else begin
                        e_tx[n] = fbit(m_pos[n] / DIV, m_data[n], p_db[n], p_msb[n]);
                    end
                end else begin
                    e_done[n] = 1'b0;
                    if (st[n]) begin
                        m_act[n]  = 1'b1;
                        m_pos[n]  = 0;
                        m_data[n] = (n == 0) ? din0 : {3'b000, din1};
                        e_tx[n] = 1'b0; e_busy[n] = 1'b1;
                    end else begin
                        e_tx[n] = 1'b1; e_busy[n] = 1'b0;
                    end
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            for (int n = 0; n < 2; n++) begin
                vectors++;
                if ({txs[n], busys[n], dones[n]} !== {e_tx[n], e_busy[n], e_done[n]}) begin
                    miscompares++;
                    if (miscompares < 40)
                        $display("FAIL model_cmp inst%0d cyc %0d: tx/busy/done got %b%b%b expected %b%b%b",
                                 n, cyc, txs[n], busys[n], dones[n], e_tx[n], e_busy[n], e_done[n]);
                end
            end
        end
    end

    // ---------------- directed helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Pulse tx_start for one cycle; returns the accept edge count.
    task automatic send(input int n, input logic [7:0] d, output int acc);
        @(negedge clk);
        st[n] = 1'b1;
        if (n == 0) din0 = d; else din1 = d[4:0];
        @(negedge clk);
        st[n] = 1'b0;
        acc = cyc;
        chk("accept_tx_busy", {30'd0, txs[n], busys[n]}, 32'b01);
    endtask

    // Sample mid-bit of nb consecutive bit slots; call within the accept cycle.
    task automatic sample_frame(input int n, input int nb, output logic [15:0] lv);
        lv = '0;
        repeat (8) @(posedge clk);
        #1 lv[0] = txs[n];
        for (int k = 1; k < nb; k++) begin
            repeat (DIV) @(posedge clk);
            #1 lv[k] = txs[n];
        end
    endtask

    // Receiver-style decode: shift left, first data bit ends in the MSB.
    function automatic logic [7:0] decode8(input logic [15:0] lv);
        logic [7:0] d;
        d = '0;
        for (int i = 1; i <= 8; i++) d = {d[6:0], lv[i]};
        return d;
    endfunction

    task automatic wait_done(input int n, input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dones[n]) begin
                at = cyc;
                return;
            end
        end
    endtask

    initial begin
        #2_000_000;
        miscompares++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int acc, acc2, at;
        logic [15:0] lv;
        logic a5_bits[10];
        logic sw_bits[8];
        logic seen;
        a5_bits = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        sw_bits = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

        // Reset, then idle for 100 cycles.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_inst0", {29'd0, txs[0], busys[0], dones[0]}, 32'b100);
            chk("idle_inst1", {29'd0, txs[1], busys[1], dones[1]}, 32'b100);
        end

        // Single frame 8'hA5, MSB first.
        send(0, 8'hA5, acc);
        sample_frame(0, 10, lv);
        for (int k = 0; k < 10; k++) chk($sformatf("a5_bit%0d", k), {31'd0, lv[k]}, {31'd0, a5_bits[k]});
        wait_done(0, 40, at);
        chk("a5_done_time", at - acc, 160);
        @(negedge clk);
        chk("a5_done_once", {31'd0, dones[0]}, 0);

        // Loopback-style decode of two bytes.
        send(0, 8'h3C, acc);
        sample_frame(0, 10, lv);
        chk("loop_3c", {24'd0, decode8(lv)}, 32'h3C);
        chk("loop_3c_stop", {31'd0, lv[9]}, 1);
        wait_done(0, 40, at);
        chk("loop_3c_done", at - acc, 160);
        send(0, 8'hFF, acc);
        sample_frame(0, 10, lv);
        chk("loop_ff", {24'd0, decode8(lv)}, 32'hFF);
        wait_done(0, 40, at);
        chk("loop_ff_done", at - acc, 160);

        // tx_start held through a frame, in_data changed mid-frame,
        // second frame accepted in the txDone cycle.
        @(negedge clk);
        st[0] = 1'b1;
        din0 = 8'h01;
        @(negedge clk);
        acc = cyc;
        fork
            sample_frame(0, 10, lv);
            begin
                repeat (80) @(negedge clk);
                din0 = 8'h80;
            end
        join
        chk("b2b_first", {24'd0, decode8(lv)}, 32'h01);
        wait_done(0, 40, at);
        chk("b2b_done_time", at - acc, 160);
        @(negedge clk);
        chk("b2b_accept2", {30'd0, txs[0], busys[0]}, 32'b01);
        acc2 = cyc;
        st[0] = 1'b0;
        chk("b2b_gap", acc2 - (acc + 9 * DIV), 17);
        sample_frame(0, 10, lv);
        chk("b2b_second", {24'd0, decode8(lv)}, 32'h80);
        wait_done(0, 40, at);
        chk("b2b_done2", at - acc2, 160);

        // Abort at cycle 50 of a frame.
        send(0, 8'h55, acc);
        repeat (50) @(negedge clk);
        en[0] = 1'b0;
        @(negedge clk);
        chk("abort_idle", {30'd0, txs[0], busys[0]}, 32'b10);
        @(negedge clk);
        en[0] = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (dones[0]) seen = 1'b1;
        end
        chk("abort_no_done", {31'd0, seen}, 0);

        // 5 data bits, 2 stop bits, LSB first.
        send(1, 8'b0001_0011, acc);
        sample_frame(1, 8, lv);
        for (int k = 0; k < 8; k++) chk($sformatf("sweep_bit%0d", k), {31'd0, lv[k]}, {31'd0, sw_bits[k]});
        wait_done(1, 40, at);
        chk("sweep_done_time", at - acc, 128);
        repeat (5) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
